// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, 16x oversampling, mid-bit sampling.
// Emits each byte as a one-cycle valid pulse; a low stop bit gives a one-cycle frame error.
module uart_rx #(
    parameter int unsigned DIV_115200 = 27,
    parameter int unsigned DIV_9600   = 326,
    parameter int unsigned DIV_4800   = 651,
    parameter int unsigned DIV_2400   = 1302
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic [2:0] baud_sel_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q;
    logic        rx_meta_q, rxs_q;
    logic [2:0]  baud_q;
    logic [10:0] div_q, div_d, div_lim;
    logic [3:0]  cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q, data_q;
    logic        data_valid_q, frame_err_q, busy_q;
    logic        tick;

    always_comb begin
        case (baud_q)
            3'd1:    div_lim = 11'(DIV_9600);
            3'd2:    div_lim = 11'(DIV_4800);
            3'd3:    div_lim = 11'(DIV_2400);
            default: div_lim = 11'(DIV_115200);
        endcase
    end

    assign tick = (state_q != S_IDLE) && (div_q == div_lim - 11'd1);

    // Divider is held at zero while idle, so the phase restarts at the start edge.
    always_comb begin
        if (state_q == S_IDLE || tick) div_d = 11'd0;
        else                           div_d = div_q + 11'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            div_q     <= 11'd0;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
            div_q     <= div_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            baud_q       <= 3'd0;
            cnt_q        <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= S_START;
                        cnt_q   <= 4'd0;
                        baud_q  <= baud_sel_i;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (cnt_q == 4'd7) begin
                            if (rxs_q) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q   <= S_DATA;
                                cnt_q     <= 4'd0;
                                bit_idx_q <= 3'd0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            shift_q   <= {rxs_q, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            if (rxs_q) begin
                                data_q       <= shift_q;
                                data_valid_q <= 1'b1;
                                busy_q       <= 1'b0;
                                state_q      <= S_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= S_BREAK;
                            end
                        end
                    end
                end
                S_BREAK: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected byte/error events,
// a negedge monitor pops and compares them whenever a pulse appears.
module tb_uart_rx;

    localparam int D0 = 27;
    localparam int D1 = 32;
    localparam int D2 = 40;
    localparam int D3 = 48;

    logic       clk, rst, rx;
    logic [2:0] baud_sel;
    logic [7:0] data;
    logic       data_valid, frame_err, busy;

    uart_rx #(.DIV_115200(D0), .DIV_9600(D1), .DIV_4800(D2), .DIV_2400(D3)) dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx), .baud_sel_i(baud_sel),
        .data_o(data), .data_valid_o(data_valid), .frame_err_o(frame_err), .busy_o(busy)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    longint     dv_times[$];
    longint     cycle = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_dv = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic int div_of(input logic [2:0] sel);
        case (sel)
            3'd1: return D1;
            3'd2: return D2;
            3'd3: return D3;
            default: return D0;
        endcase
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, want, cycle);
        end
    endtask

    task automatic push_good(input logic [7:0] b);
        exp_t e;
        e.err = 1'b0;
        e.d   = b;
        exp_q.push_back(e);
        last_good = b;
    endtask

    task automatic push_err();
        exp_t e;
        e.err = 1'b1;
        e.d   = last_good;
        exp_q.push_back(e);
    endtask

    // Drives the first nper bit periods of an 8N1 frame (start, 8 data LSB first, stop).
    task automatic send_frame(input logic [7:0] b, input int div, input logic stop_val, input int nper);
        logic [9:0] bits;
        bits = {stop_val, b, 1'b0};
        for (int k = 0; k < nper; k++) begin
            @(negedge clk);
            rx = bits[k];
            repeat (16 * div - 1) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid || frame_err) begin
                check("pulse_exclusive", data_valid && frame_err, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {data_valid, frame_err}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", frame_err, e.err);
                    check("pulse_data", data, e.d);
                end
            end
            if (data_valid) begin
                check("dv_one_cycle", prev_dv, 0);
                dv_times.push_back(cycle);
            end
            prev_dv <= data_valid;
        end else begin
            prev_dv <= 1'b0;
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sel;
        logic [7:0] b;
        longint     dt;

        rst = 1'b1;
        rx = 1'b1;
        baud_sel = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_dv", data_valid, 0);
        check("rst_fe", frame_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        baud_sel = 3'd0;
        push_good(8'hA5);
        send_frame(8'hA5, D0, 1'b1, 10);
        check("busy_after_a5", busy, 0);
        check("data_hold_a5", data, 8'hA5);
        repeat (30) @(negedge clk);

        baud_sel = 3'd1;
        push_good(8'h3C);
        push_good(8'hFF);
        send_frame(8'h3C, D1, 1'b1, 10);
        send_frame(8'hFF, D1, 1'b1, 10);
        check("busy_after_b2b", busy, 0);
        check("b2b_pulse_count", dv_times.size(), 3);
        if (dv_times.size() >= 2) begin
            dt = dv_times[dv_times.size() - 1] - dv_times[dv_times.size() - 2];
            check("b2b_spacing_ok", (dt >= 10 * 16 * D1 - 2) && (dt <= 10 * 16 * D1 + 2), 1);
        end
        repeat (30) @(negedge clk);

        baud_sel = 3'd0;
        push_err();
        send_frame(8'h55, D0, 1'b0, 10);
        repeat (3 * 16 * D0) @(negedge clk);
        check("busy_in_break", busy, 1);
        check("data_kept_break", data, 8'hFF);
        rx = 1'b1;
        repeat (16 * D0) @(negedge clk);
        check("busy_after_break", busy, 0);

        baud_sel = 3'd2;
        @(negedge clk);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        check("busy_glitch", busy, 1);
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (8 * D2 + 40) @(negedge clk);
        check("busy_after_glitch", busy, 0);

        baud_sel = 3'd3;
        send_frame(8'h81, D3, 1'b1, 4);
        @(negedge clk);
        rx = 1'b0;
        repeat (8 * D3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_data", data, 8'h00);
        last_good = 8'h00;
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * 16 * D3) @(negedge clk);
        push_good(8'h81);
        send_frame(8'h81, D3, 1'b1, 10);
        check("data_after_rst", data, 8'h81);
        repeat (30) @(negedge clk);

        baud_sel = 3'd0;
        push_good(8'h12);
        fork
            send_frame(8'h12, D0, 1'b1, 10);
            begin
                repeat (4 * 16 * D0) @(negedge clk);
                baud_sel = 3'd1;
            end
        join
        check("data_switch", data, 8'h12);
        repeat (30) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            sel = 3'($urandom_range(0, 7));
            b   = 8'($urandom);
            baud_sel = sel;
            push_good(b);
            send_frame(b, div_of(sel), 1'b1, 10);
            check("busy_after_rand", busy, 0);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        repeat (200) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
